adp_dmem_bridge: RTL

ADP_DMEM_BRIDGE -- requirements
Module: adp_dmem_bridge

---
 rtl/adp_dmem_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/adp_dmem_bridge.sv
// Shares one SRAM port between the core data path and the debug port (ADP).
// ADP requests are level-held, windowed to 0x7000_0000-0x7000_1FFF and aborted after TIMEOUT_CYCLES.
module adp_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        adp_tck_i_buf,
    input  logic        adp_trst_i_buf,
    input  logic        adp_debug_mode,
    input  logic [31:0] adp_dmem_addr,
    input  logic [3:0]  adp_dmem_rmask,
    input  logic [3:0]  adp_dmem_wmask,
    input  logic [31:0] adp_dmem_wdata,
    output logic [31:0] adp_dmem_rdata,
    input  logic [31:0] core_dmem_addr,
    input  logic [3:0]  core_dmem_rmask,
    input  logic [3:0]  core_dmem_wmask,
    input  logic [31:0] core_dmem_wdata,
    output logic [31:0] core_dmem_rdata,
    output logic        core_dmem_resp,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_rmask,
    output logic [3:0]  sram_wmask,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_resp,
    output logic        adp_busy,
    output logic        adp_err
);

    localparam int          CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [18:0] ADP_WINDOW = 19'h38000;

    typedef enum logic [1:0] {IDLE, CORE_ACC, ADP_ACC, ADP_DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      adp_addr_q, adp_wdata_q, adp_rdata_q;
    logic [3:0]       adp_rmask_q, adp_wmask_q;
    logic [31:0]      core_addr_q, core_wdata_q, core_rdata_q;
    logic [3:0]       core_rmask_q, core_wmask_q;
    logic             core_resp_q, adp_err_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic adp_req, adp_both, adp_in_window, core_req, adp_timeout;

    assign adp_req       = adp_debug_mode && (|adp_dmem_rmask || |adp_dmem_wmask);
    assign adp_both      = |adp_dmem_rmask && |adp_dmem_wmask;
    assign adp_in_window = (adp_dmem_addr[31:13] == ADP_WINDOW);
    assign core_req      = !adp_debug_mode && (|core_dmem_rmask || |core_dmem_wmask);
    assign adp_timeout   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge adp_tck_i_buf or posedge adp_trst_i_buf) begin
        if (adp_trst_i_buf) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (adp_req) begin
                    state_nxt = adp_in_window ? ADP_ACC : ADP_DONE;
                end else if (core_req) begin
                    state_nxt = CORE_ACC;
                end
            end
            ADP_ACC: begin
                if (sram_resp || adp_timeout) begin
                    state_nxt = ADP_DONE;
                end
            end
            // Hold until the level-held request is withdrawn so it is served once.
            ADP_DONE: begin
                if (!(|adp_dmem_rmask) && !(|adp_dmem_wmask)) begin
                    state_nxt = IDLE;
                end
            end
            CORE_ACC: begin
                if (sram_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adp_tck_i_buf or posedge adp_trst_i_buf) begin
        if (adp_trst_i_buf) begin
            adp_addr_q   <= '0;
            adp_rmask_q  <= '0;
            adp_wmask_q  <= '0;
            adp_wdata_q  <= '0;
            adp_rdata_q  <= '0;
            adp_err_q    <= 1'b0;
            tmo_cnt      <= '0;
            core_addr_q  <= '0;
            core_rmask_q <= '0;
            core_wmask_q <= '0;
            core_wdata_q <= '0;
            core_rdata_q <= '0;
            core_resp_q  <= 1'b0;
        end else begin
            core_resp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (adp_req) begin
                        adp_addr_q  <= adp_dmem_addr;
                        // With both masks set only the write goes out.
                        adp_rmask_q <= adp_both ? 4'h0 : adp_dmem_rmask;
                        adp_wmask_q <= adp_dmem_wmask;
                        adp_wdata_q <= adp_dmem_wdata;
                        adp_err_q   <= !adp_in_window || adp_both;
                        tmo_cnt     <= '0;
                        if (!adp_in_window) begin
                            adp_rdata_q <= ERR_DATA;
                        end
                    end else if (core_req) begin
                        core_addr_q  <= core_dmem_addr;
                        core_rmask_q <= core_dmem_rmask;
                        core_wmask_q <= core_dmem_wmask;
                        core_wdata_q <= core_dmem_wdata;
                    end
                end
                ADP_ACC: begin
                    if (sram_resp) begin
                        if (|adp_rmask_q) begin
                            adp_rdata_q <= sram_rdata;
                        end
                    end else if (adp_timeout) begin
                        adp_err_q   <= 1'b1;
                        adp_rdata_q <= ERR_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CORE_ACC: begin
                    if (sram_resp) begin
                        core_resp_q  <= 1'b1;
                        core_rdata_q <= sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM request is decoded from state so reset removes it without waiting for a clock.
    always_comb begin
        sram_addr  = '0;
        sram_rmask = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (state == ADP_ACC) begin
            sram_addr  = adp_addr_q;
            sram_rmask = adp_rmask_q;
            sram_wmask = adp_wmask_q;
            sram_wdata = adp_wdata_q;
        end else if (state == CORE_ACC) begin
            sram_addr  = core_addr_q;
            sram_rmask = core_rmask_q;
            sram_wmask = core_wmask_q;
            sram_wdata = core_wdata_q;
        end
    end

    assign adp_busy        = (state == ADP_ACC);
    assign adp_err         = adp_err_q;
    assign adp_dmem_rdata  = adp_rdata_q;
    assign core_dmem_rdata = core_rdata_q;
    assign core_dmem_resp  = core_resp_q;

endmodule
